// File: rtl/data_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported 24-bit data RAM.
// Each transaction runs IDLE -> ISSUE -> (CAPTURE) -> DONE, and every output is driven from a register.
module data_ram_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 24,
    parameter int RAM_BYTES         = 32768
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req0,
    input  logic                         req1,
    input  logic                         rnw0,
    input  logic                         rnw1,
    input  logic [ADDRESS_BUS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_BUS_WIDTH-1:0] addr1,
    input  logic [DATA_BUS_WIDTH-1:0]    wdata0,
    input  logic [DATA_BUS_WIDTH-1:0]    wdata1,
    output logic                         ack0,
    output logic                         ack1,
    output logic                         err0,
    output logic                         err1,
    output logic [DATA_BUS_WIDTH-1:0]    rdata,
    output logic                         busy,
    output logic                         ram_cs,
    output logic                         ram_rnw,
    output logic [ADDRESS_BUS_WIDTH-1:0] ram_addr,
    output logic [DATA_BUS_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_BUS_WIDTH-1:0]    ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam longint unsigned MAX_ADDR = longint'(RAM_BYTES) - 3;

    state_t                         state_q, state_d;
    logic                           lastGrant_q, lastGrant_d;
    logic                           grant_q, grant_d;
    logic                           rnw_q, rnw_d;
    logic                           oor_q, oor_d;
    logic [DATA_BUS_WIDTH-1:0]      rdata_q, rdata_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   ramAddr_q, ramAddr_d;
    logic [DATA_BUS_WIDTH-1:0]      ramWdata_q, ramWdata_d;
    logic                           ramCs_q, ramCs_d;
    logic                           ramRnw_q, ramRnw_d;
    logic                           ack0_q, ack0_d, ack1_q, ack1_d;
    logic                           err0_q, err0_d, err1_q, err1_d;
    logic                           busy_q, busy_d;

    logic                           win;
    logic                           selRnw;
    logic [ADDRESS_BUS_WIDTH-1:0]   selAddr;
    logic [DATA_BUS_WIDTH-1:0]      selWdata;
    logic                           selOor;

    // On a tie the port that did not win last time is served.
    assign win      = (req0 && req1) ? ~lastGrant_q : req1;
    assign selRnw   = win ? rnw1 : rnw0;
    assign selAddr  = win ? addr1 : addr0;
    assign selWdata = win ? wdata1 : wdata0;
    assign selOor   = longint'(selAddr) > MAX_ADDR;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        rnw_d       = rnw_q;
        oor_d       = oor_q;
        rdata_d     = rdata_q;
        ramAddr_d   = ramAddr_q;
        ramWdata_d  = ramWdata_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d     = win;
                    lastGrant_d = win;
                    rnw_d       = selRnw;
                    oor_d       = selOor;
                    if (selOor) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ISSUE;
                        ramAddr_d  = selAddr;
                        ramWdata_d = selWdata;
                    end
                end
            end
            ISSUE:   state_d = rnw_q ? CAPTURE : DONE;
            CAPTURE: begin
                rdata_d = ram_rdata;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered alongside it.
        ramCs_d  = (state_d == ISSUE);
        ramRnw_d = (state_d == ISSUE) ? rnw_d : 1'b1;
        ack0_d   = (state_d == DONE) && !grant_d;
        ack1_d   = (state_d == DONE) && grant_d;
        err0_d   = ack0_d && oor_d;
        err1_d   = ack1_d && oor_d;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            rnw_q       <= 1'b1;
            oor_q       <= 1'b0;
            rdata_q     <= '0;
            ramAddr_q   <= '0;
            ramWdata_q  <= '0;
            ramCs_q     <= 1'b0;
            ramRnw_q    <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            rnw_q       <= rnw_d;
            oor_q       <= oor_d;
            rdata_q     <= rdata_d;
            ramAddr_q   <= ramAddr_d;
            ramWdata_q  <= ramWdata_d;
            ramCs_q     <= ramCs_d;
            ramRnw_q    <= ramRnw_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            busy_q      <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign ram_cs    = ramCs_q;
    assign ram_rnw   = ramRnw_q;
    assign ram_addr  = ramAddr_q;
    assign ram_wdata = ramWdata_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter: a byte-array reference model predicts the order and results of the acks.
// A negedge monitor compares each ack against the predictions queued up by the stimulus tasks.
module tb_data_ram_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 24;
    localparam int RAM_BYTES = 32768;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, rnw0, rnw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata;
    logic          busy, ram_cs, ram_rnw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    data_ram_arbiter #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH(DW),
        .RAM_BYTES(RAM_BYTES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy),
        .ram_cs(ram_cs), .ram_rnw(ram_rnw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    typedef struct {
        bit            port;
        bit            err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          expQ[$];
    logic [7:0]    mem[RAM_BYTES];
    logic [7:0]    refMem[RAM_BYTES];
    logic [DW-1:0] modelRdata;
    bit            modelLast;
    int            checks;
    int            errors;
    bit            prevCs;
    bit            prevAck;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM: registers read data on the edge that sees chip select.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rnw) begin
                ram_rdata <= {mem[int'(ram_addr)+2], mem[int'(ram_addr)+1], mem[int'(ram_addr)]};
            end else begin
                mem[int'(ram_addr)]   = ram_wdata[7:0];
                mem[int'(ram_addr)+1] = ram_wdata[15:8];
                mem[int'(ram_addr)+2] = ram_wdata[23:16];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference transaction: range rule, little-endian bytes, rdata only changes on a good read.
    task automatic modelTxn(input bit port, input bit rnw, input int addr, input logic [DW-1:0] wd,
                            output int lat, output int inRange);
        bit e;
        e = addr > RAM_BYTES - 3;
        if (!e) begin
            if (rnw) modelRdata = {refMem[addr+2], refMem[addr+1], refMem[addr]};
            else begin
                refMem[addr]   = wd[7:0];
                refMem[addr+1] = wd[15:8];
                refMem[addr+2] = wd[23:16];
            end
        end
        expQ.push_back('{port: port, err: e, rdata: modelRdata});
        modelLast = port;
        lat       = e ? 1 : (rnw ? 3 : 2);
        inRange   = e ? 0 : 1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_flags"}, {25'd0, ack0, ack1, err0, err1, busy, ram_cs, ram_rnw}, 32'h1);
        checkOutput({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'h0);
        checkOutput({tag, "_ram_wdata"}, {8'd0, ram_wdata}, 32'h0);
        checkOutput({tag, "_rdata"}, {8'd0, rdata}, 32'h0);
    endtask

    // One arbitration round from IDLE: mask bit0/bit1 selects which ports request together.
    task automatic applyStimulus(input bit [1:0] mask,
                                 input bit rA, input int aA, input logic [DW-1:0] dA,
                                 input bit rB, input int aB, input logic [DW-1:0] dB);
        bit firstPort, pend0, pend1;
        int lat1, lat2, ir, expCs, csSeen, cyc, ackCyc1, ackCyc2;
        firstPort = (mask == 2'b11) ? !modelLast : mask[1];
        lat2 = 0;
        modelTxn(firstPort, firstPort ? rB : rA, firstPort ? aB : aA, firstPort ? dB : dA, lat1, ir);
        expCs = ir;
        if (mask == 2'b11) begin
            modelTxn(!firstPort, firstPort ? rA : rB, firstPort ? aA : aB, firstPort ? dA : dB, lat2, ir);
            expCs += ir;
        end
        @(negedge clk);
        rnw0 = rA; addr0 = AW'(aA); wdata0 = dA;
        rnw1 = rB; addr1 = AW'(aB); wdata1 = dB;
        req0 = mask[0]; req1 = mask[1];
        pend0 = mask[0]; pend1 = mask[1];
        cyc = 0; csSeen = 0; ackCyc1 = 0; ackCyc2 = 0;
        while ((pend0 || pend1) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ram_cs) csSeen++;
            if (ack0 && pend0) begin
                req0 = 1'b0; pend0 = 1'b0;
                if (firstPort == 1'b0) ackCyc1 = cyc; else ackCyc2 = cyc;
            end
            if (ack1 && pend1) begin
                req1 = 1'b0; pend1 = 1'b0;
                if (firstPort == 1'b1) ackCyc1 = cyc; else ackCyc2 = cyc;
            end
        end
        if (pend0 || pend1) begin
            checkOutput("round_timeout", {30'd0, pend1, pend0}, 32'h0);
            req0 = 1'b0; req1 = 1'b0;
        end else begin
            checkOutput("first_latency", ackCyc1, lat1);
            if (mask == 2'b11) checkOutput("second_ack_gap", ackCyc2 - ackCyc1, lat2 + 1);
            checkOutput("ram_cs_cycles", csSeen, expCs);
        end
    endtask

    // Both ports request continuously; port 0 reads 0x10, port 1 writes 0x30.
    task automatic holdBoth(input int n);
        int lat, ir, acks, cyc;
        bit p;
        for (int i = 0; i < n; i++) begin
            p = !modelLast;
            modelTxn(p, !p, p ? 'h30 : 'h10, p ? 24'h5A5A5A : 24'h0, lat, ir);
        end
        @(negedge clk);
        rnw0 = 1'b1; addr0 = 16'h0010; wdata0 = 24'h0;
        rnw1 = 1'b0; addr1 = 16'h0030; wdata1 = 24'h5A5A5A;
        req0 = 1'b1; req1 = 1'b1;
        acks = 0; cyc = 0;
        while (acks < n && cyc < 20 * n) begin
            @(negedge clk);
            cyc++;
            acks += int'(ack0) + int'(ack1);
            if (acks >= n) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checkOutput("hold_ack_count", acks, n);
    endtask

    function automatic int pickAddr();
        case ($urandom_range(0, 7))
            0: return 'h10;
            1: return 'h20;
            2: return 'h30;
            3: return RAM_BYTES - 3;
            4: return RAM_BYTES - 2;
            5: return 'hFFFF;
            default: return 3 * $urandom_range(0, 20);
        endcase
    endfunction

    // Monitor: every ack is matched against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prevCs  = 1'b0;
            prevAck = 1'b0;
        end else begin
            if (ram_cs) checkOutput("ram_cs_back_to_back", {31'd0, prevCs}, 32'h0);
            if (ack0 || ack1) begin
                checkOutput("ack_double_pulse", {31'd0, prevAck}, 32'h0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", {30'd0, ack1, ack0}, 32'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ack_vector", {30'd0, ack1, ack0}, e.port ? 32'h2 : 32'h1);
                    checkOutput("err_vector", {30'd0, err1, err0}, e.err ? (e.port ? 32'h2 : 32'h1) : 32'h0);
                    checkOutput("rdata", {8'd0, rdata}, {8'd0, e.rdata});
                end
            end
            prevCs  = ram_cs;
            prevAck = ack0 || ack1;
        end
    end

    initial begin
        bit [1:0] mask;
        checks = 0; errors = 0;
        modelLast = 1'b1; modelRdata = '0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rnw0 = 1'b1; rnw1 = 1'b1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < RAM_BYTES; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            refMem[i] = 8'(i * 7 + 3);
        end
        mem[16'h10] = 8'h14; mem[16'h11] = 8'h00; mem[16'h12] = 8'h00;
        refMem[16'h10] = 8'h14; refMem[16'h11] = 8'h00; refMem[16'h12] = 8'h00;

        #22;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'b01, 1'b1, 'h10, 24'h0, 1'b1, 'h0, 24'h0);
        applyStimulus(2'b10, 1'b1, 'h0, 24'h0, 1'b0, 'h20, 24'hABCDEF);
        applyStimulus(2'b10, 1'b1, 'h0, 24'h0, 1'b1, 'h20, 24'h0);
        applyStimulus(2'b11, 1'b1, 'h10, 24'h0, 1'b1, 'h20, 24'h0);
        applyStimulus(2'b11, 1'b1, 'h20, 24'h0, 1'b1, 'h10, 24'h0);
        applyStimulus(2'b01, 1'b1, RAM_BYTES - 2, 24'h0, 1'b1, 'h0, 24'h0);
        holdBoth(10);

        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            applyStimulus(mask, 1'($urandom), pickAddr(), DW'($urandom),
                                1'($urandom), pickAddr(), DW'($urandom));
        end

        // Reset arrives while a write is in ISSUE: the write must be lost and never acked.
        @(negedge clk);
        req1 = 1'b1; rnw1 = 1'b0; addr1 = 16'h0020; wdata1 = 24'h123456;
        @(posedge clk);
        #2;
        checkOutput("issue_cs_before_reset", {31'd0, ram_cs}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("ram_word_after_abort", {8'd0, mem[16'h22], mem[16'h21], mem[16'h20]},
                    {8'd0, refMem[16'h22], refMem[16'h21], refMem[16'h20]});
        rst_n = 1'b1;
        modelLast = 1'b1; modelRdata = '0;

        applyStimulus(2'b11, 1'b1, 'h10, 24'h0, 1'b1, 'h20, 24'h0);
        applyStimulus(2'b11, 1'b0, 'h40, 24'h010203, 1'b1, 'h40, 24'h0);

        repeat (4) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
